spi_transaction_sequencer: RTL and testbench
============================================

Name: spi_transaction_sequencer

Overview:
Upstream command front-end for generic_spi_controller, in the AXI clock domain. Accepts a transaction command (bit length plus payload words) on valid/ready streams and loads the payload into controller memory with correctly paced write strobes. It then pulses run, tracks controller status until completion, and streams the captured POCI words back out on a response stream. This removes software polling of pointers and status.

Parameters:
MEM_DEPTH, 64, controller memory depth in 32b words; must match the controller.
TIMEOUT_CYCLES, 1000000, max axi_clk cycles allowed in the wait states before an error is flagged.

Ports:
axi_clk  in  1  clock
axi_resetn  in  1  reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_len_bits  in  32  transaction length in bits
wr_valid  in  1  payload word valid
wr_ready  out  1  payload word accepted when valid&ready
wr_data  in  32  payload word; bit0 is shifted first
rsp_valid  out  1  response word valid
rsp_ready  in  1  response consumer ready
rsp_data  out  32  captured POCI word
rsp_last  out  1  marks the final response word
ctl_mem_write  out  32  to controller mem_write
ctl_mem_write_strb  out  1  to controller mem_write_strb
ctl_mem_write_ptr_reset  out  1  to controller
ctl_mem_read  in  32  from controller mem_read
ctl_mem_read_strb  out  1  to controller
ctl_mem_read_ptr_reset  out  1  to controller
ctl_transaction_len  out  32  to controller transaction_len
ctl_run  out  1  to controller run
ctl_status  in  3  from controller status; bit2 is triggered
busy  out  1  high whenever state != IDLE
err_len  out  1  sticky: length out of range
err_timeout  out  1  sticky: wait timed out

Behaviour:
- One clock, axi_clk. Reset axi_resetn is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; counters 0. Reset mid-operation returns to IDLE immediately. Partially loaded controller memory is not cleaned up.
- All outputs are registered except cmd_ready (= state==IDLE), wr_ready (= state==LOAD) and busy.
- nwords = (cmd_len_bits+31)>>5, computed in 33b arithmetic with no overflow.
- On cmd accept: err_len and err_timeout clear; ctl_transaction_len <= cmd_len_bits.
- FSM states: IDLE, WPTR_RST, LOAD, LOAD_HOLD, RUN, WAIT_TRIG, WAIT_DONE, RPTR_RST, READ_FETCH, READ_PRESENT.
- IDLE:
  - On cmd handshake with len==0: stay IDLE; no memory access, no run, no response.
  - On cmd handshake with len > MEM_DEPTH*32: set err_len; stay IDLE; consume no payload.
  - Otherwise go to WPTR_RST.
- WPTR_RST: ctl_mem_write_ptr_reset=1 for exactly one cycle, then LOAD.
- LOAD: on wr handshake, ctl_mem_write<=wr_data and ctl_mem_write_strb=1 for one cycle, then LOAD_HOLD. With no handshake, remain in LOAD.
- LOAD_HOLD: strobe low; ctl_mem_write held. This is required because the controller captures mem_write one cycle after the strobe.
  - Go to RUN when the word count reaches nwords, else back to LOAD.
  - Maximum rate is 1 word per 2 cycles; strobes are never back-to-back.
- RUN: ctl_run=1 for exactly one cycle, then WAIT_TRIG.
- WAIT_TRIG: wait for ctl_status[2]==1, then WAIT_DONE.
- WAIT_DONE: wait for ctl_status[2]==0, which means the controller reached DONE and cs_b returned high. Then RPTR_RST.
- Timeout: a cycle counter runs across WAIT_TRIG and WAIT_DONE. When it reaches TIMEOUT_CYCLES, set err_timeout and go to IDLE with no response.
- RPTR_RST: ctl_mem_read_ptr_reset=1 for one cycle, then READ_FETCH.
- READ_FETCH: rsp_data<=ctl_mem_read; rsp_last<=(word index==nwords-1); rsp_valid<=1. Then READ_PRESENT.
- READ_PRESENT: hold rsp_* stable while rsp_ready is low. On handshake:
  - rsp_valid<=0 and ctl_mem_read_strb=1 for one cycle.
  - If this was the last word, go to IDLE; else go to READ_FETCH. The pointer advances before the next fetch samples.
- Unused high bits of the last word are passed through unmodified.
- cmd_valid while busy is ignored, since cmd_ready=0. wr_valid outside LOAD is ignored.

Decomposition:
- Package spi_seq_pkg: state enum seq_state_t (4b); constant STATUS_TRIG_BIT=2; localparam WORD_BITS=32.
- No sub-module needed. Timeout counter and word counter stay inline in a single always_ff plus an always_comb next-state block.

Test Plan:
- len=64, words 0xDEADBEEF,0x12345678 → two write strobes ≥2 cycles apart; ctl_mem_write stable during each strobe+1 cycle; one run pulse; after a controller model toggles status[2] 1→0, two rsp words with the model's read data, rsp_last on the second.
- len=33 → nwords=2, two loads and two responses; len=32 → exactly one of each.
- len=0 → cmd accepted; no strobes, run or rsp; busy never asserts.
- len=MEM_DEPTH*32+1 (2049) → err_len=1, wr_ready never asserts, back to IDLE; next valid cmd clears err_len.
- Model holds status[2]=1 forever, TIMEOUT_CYCLES=100 → err_timeout set at 100 cycles in wait states, state IDLE, no rsp_valid.
- rsp_ready held low 10 cycles mid-readback, and axi_resetn pulsed during LOAD → rsp_data stable with no extra read strobes; after reset, all outputs 0 and a new cmd is accepted.

Source files
------------

// File: rtl/spi_transaction_sequencer_pkg.sv
// Shared definitions for the SPI transaction sequencer: FSM state codes,
// word geometry and the bit-length to word-count helper.
package spi_seq_pkg;

    localparam int WORD_BITS       = 32;
    localparam int STATUS_TRIG_BIT = 2;

    typedef logic [3:0] seq_state_t;

    localparam seq_state_t ST_IDLE         = 4'd0;
    localparam seq_state_t ST_WPTR_RST     = 4'd1;
    localparam seq_state_t ST_LOAD         = 4'd2;
    localparam seq_state_t ST_LOAD_HOLD    = 4'd3;
    localparam seq_state_t ST_RUN          = 4'd4;
    localparam seq_state_t ST_WAIT_TRIG    = 4'd5;
    localparam seq_state_t ST_WAIT_DONE    = 4'd6;
    localparam seq_state_t ST_RPTR_RST     = 4'd7;
    localparam seq_state_t ST_READ_FETCH   = 4'd8;
    localparam seq_state_t ST_READ_PRESENT = 4'd9;

    // Round a bit length up to whole words; 33 bits so a full 32b length cannot wrap
    function automatic logic [32:0] len_to_words(input logic [31:0] len_bits);
        return (33'(len_bits) + 33'(WORD_BITS - 1)) >> $clog2(WORD_BITS);
    endfunction

endpackage

// File: rtl/spi_transaction_sequencer.sv
// Command front-end for generic_spi_controller: loads the payload into the
// controller memory, pulses run, waits for the transaction to finish and
// streams the captured POCI words back on the response stream.
module spi_transaction_sequencer
    import spi_seq_pkg::*;
#(
    parameter int MEM_DEPTH      = 64,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        axi_clk,
    input  logic        axi_resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_len_bits,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_last,
    output logic [31:0] ctl_mem_write,
    output logic        ctl_mem_write_strb,
    output logic        ctl_mem_write_ptr_reset,
    input  logic [31:0] ctl_mem_read,
    output logic        ctl_mem_read_strb,
    output logic        ctl_mem_read_ptr_reset,
    output logic [31:0] ctl_transaction_len,
    output logic        ctl_run,
    input  logic [2:0]  ctl_status,
    output logic        busy,
    output logic        err_len,
    output logic        err_timeout
);

    localparam logic [32:0] MAX_LEN_BITS = 33'(MEM_DEPTH * WORD_BITS);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    seq_state_t  state;
    seq_state_t  state_next;
    logic [31:0] word_cnt;
    logic [31:0] nwords;
    logic [31:0] timeout_cnt;
    logic [32:0] cmd_nwords;
    logic        cmd_fire;
    logic        wr_fire;
    logic        rsp_fire;
    logic        len_zero;
    logic        len_too_long;
    logic        timeout_hit;
    logic        status_trig;
    logic        unused_bits;

    assign cmd_ready    = (state == ST_IDLE);
    assign wr_ready     = (state == ST_LOAD);
    assign busy         = (state != ST_IDLE);
    assign cmd_fire     = cmd_valid & cmd_ready;
    assign wr_fire      = wr_valid & wr_ready;
    assign rsp_fire     = rsp_valid & rsp_ready & (state == ST_READ_PRESENT);
    assign cmd_nwords   = len_to_words(cmd_len_bits);
    assign len_zero     = (cmd_len_bits == 32'd0);
    assign len_too_long = ({1'b0, cmd_len_bits} > MAX_LEN_BITS);
    assign timeout_hit  = (timeout_cnt == TIMEOUT_LAST);
    assign status_trig  = ctl_status[STATUS_TRIG_BIT];
    assign unused_bits  = ^{ctl_status[1:0], cmd_nwords[32]};

    // Next-state selection; a timeout in either wait state wins over a status change
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cmd_fire && !len_zero && !len_too_long) begin
                    state_next = ST_WPTR_RST;
                end
            end
            ST_WPTR_RST:  state_next = ST_LOAD;
            ST_LOAD: begin
                if (wr_fire) begin
                    state_next = ST_LOAD_HOLD;
                end
            end
            ST_LOAD_HOLD: state_next = (word_cnt == nwords) ? ST_RUN : ST_LOAD;
            ST_RUN:       state_next = ST_WAIT_TRIG;
            ST_WAIT_TRIG: begin
                if (timeout_hit) begin
                    state_next = ST_IDLE;
                end else if (status_trig) begin
                    state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (timeout_hit) begin
                    state_next = ST_IDLE;
                end else if (!status_trig) begin
                    state_next = ST_RPTR_RST;
                end
            end
            ST_RPTR_RST:  state_next = ST_READ_FETCH;
            ST_READ_FETCH: begin
                // The read strobe register is high in the first fetch cycle after a
                // handshake; sampling waits a cycle so the controller pointer has moved
                if (!ctl_mem_read_strb) begin
                    state_next = ST_READ_PRESENT;
                end
            end
            ST_READ_PRESENT: begin
                if (rsp_fire) begin
                    state_next = rsp_last ? ST_IDLE : ST_READ_FETCH;
                end
            end
            default:      state_next = ST_IDLE;
        endcase
    end

    // State, counters and all registered controller/response outputs
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state                   <= ST_IDLE;
            word_cnt                <= '0;
            nwords                  <= '0;
            timeout_cnt             <= '0;
            rsp_valid               <= 1'b0;
            rsp_data                <= '0;
            rsp_last                <= 1'b0;
            ctl_mem_write           <= '0;
            ctl_mem_write_strb      <= 1'b0;
            ctl_mem_write_ptr_reset <= 1'b0;
            ctl_mem_read_strb       <= 1'b0;
            ctl_mem_read_ptr_reset  <= 1'b0;
            ctl_transaction_len     <= '0;
            ctl_run                 <= 1'b0;
            err_len                 <= 1'b0;
            err_timeout             <= 1'b0;
        end else begin
            state                   <= state_next;
            ctl_mem_write_ptr_reset <= (state_next == ST_WPTR_RST);
            ctl_run                 <= (state_next == ST_RUN);
            ctl_mem_read_ptr_reset  <= (state_next == ST_RPTR_RST);
            ctl_mem_write_strb      <= wr_fire;
            ctl_mem_read_strb       <= rsp_fire;
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        ctl_transaction_len <= cmd_len_bits;
                        err_len             <= len_too_long;
                        err_timeout         <= 1'b0;
                        nwords              <= cmd_nwords[31:0];
                        word_cnt            <= '0;
                    end
                end
                ST_LOAD: begin
                    if (wr_fire) begin
                        ctl_mem_write <= wr_data;
                        word_cnt      <= word_cnt + 32'd1;
                    end
                end
                ST_RUN: timeout_cnt <= '0;
                ST_WAIT_TRIG, ST_WAIT_DONE: begin
                    if (timeout_hit) begin
                        err_timeout <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + 32'd1;
                    end
                end
                ST_RPTR_RST: word_cnt <= '0;
                ST_READ_FETCH: begin
                    if (!ctl_mem_read_strb) begin
                        rsp_data  <= ctl_mem_read;
                        rsp_last  <= (word_cnt == nwords - 32'd1);
                        rsp_valid <= 1'b1;
                    end
                end
                ST_READ_PRESENT: begin
                    if (rsp_fire) begin
                        rsp_valid <= 1'b0;
                        word_cnt  <= word_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_transaction_sequencer.sv
// Bench for spi_transaction_sequencer: a behavioural controller model (memory,
// pointers, delayed write capture, trigger status) plus randomized payloads.
// Expected responses are the written payload scrambled by a per-run mask.
module tb_spi_transaction_sequencer;

    localparam int MEM_DEPTH = 64;
    localparam int TO_CYCLES = 100;

    logic        axi_clk = 1'b0;
    logic        axi_resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_len_bits = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic [31:0] ctl_mem_write;
    logic        ctl_mem_write_strb;
    logic        ctl_mem_write_ptr_reset;
    logic [31:0] ctl_mem_read;
    logic        ctl_mem_read_strb;
    logic        ctl_mem_read_ptr_reset;
    logic [31:0] ctl_transaction_len;
    logic        ctl_run;
    logic [2:0]  ctl_status;
    logic        busy;
    logic        err_len;
    logic        err_timeout;

    int total_checks = 0;
    int bad_checks = 0;

    spi_transaction_sequencer #(.MEM_DEPTH(MEM_DEPTH), .TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .axi_clk(axi_clk), .axi_resetn(axi_resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len_bits(cmd_len_bits),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .ctl_mem_write(ctl_mem_write), .ctl_mem_write_strb(ctl_mem_write_strb),
        .ctl_mem_write_ptr_reset(ctl_mem_write_ptr_reset), .ctl_mem_read(ctl_mem_read),
        .ctl_mem_read_strb(ctl_mem_read_strb), .ctl_mem_read_ptr_reset(ctl_mem_read_ptr_reset),
        .ctl_transaction_len(ctl_transaction_len), .ctl_run(ctl_run), .ctl_status(ctl_status),
        .busy(busy), .err_len(err_len), .err_timeout(err_timeout)
    );

    always #5 axi_clk = ~axi_clk;

    // Controller model state
    logic [31:0] model_mem  [0:63];
    logic [31:0] model_mask [0:63];
    logic [6:0]  wptr;
    logic [6:0]  rptr;
    logic        strb_d;
    int          phase;
    int          pcnt;
    int          trig_delay = 3;
    int          busy_len = 6;
    bit          model_hang = 1'b0;

    assign ctl_status   = {(phase == 2), 2'b00};
    assign ctl_mem_read = model_mem[rptr[5:0]] ^ model_mask[rptr[5:0]];

    // Controller model: captures mem_write the cycle after the strobe, walks the
    // read pointer on read strobes, and raises status[2] for a while after run
    always @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            wptr <= '0; rptr <= '0; strb_d <= 1'b0; phase <= 0; pcnt <= 0;
        end else begin
            strb_d <= ctl_mem_write_strb;
            if (ctl_mem_write_ptr_reset) wptr <= '0;
            else if (strb_d) begin
                model_mem[wptr[5:0]] <= ctl_mem_write;
                wptr <= wptr + 7'd1;
            end
            if (ctl_mem_read_ptr_reset) rptr <= '0;
            else if (ctl_mem_read_strb) rptr <= rptr + 7'd1;
            if (ctl_run) begin
                phase <= 1; pcnt <= trig_delay;
            end else if (phase == 1) begin
                if (pcnt == 0) begin phase <= 2; pcnt <= busy_len; end
                else pcnt <= pcnt - 1;
            end else if (phase == 2 && !model_hang) begin
                if (pcnt == 0) phase <= 0;
                else pcnt <= pcnt - 1;
            end
        end
    end

    // Interface monitors
    logic [31:0] wr_log [$];
    int gap_bad, hold_bad, run_count, rd_strb_count, busy_count, wr_ready_count, rsp_valid_count;
    logic        prev_wstrb = 1'b0;
    logic [31:0] prev_wdata = '0;

    // Observe strobes, pulses and handshake enables once per cycle on the falling edge
    always @(negedge axi_clk) begin
        prev_wstrb <= ctl_mem_write_strb;
        prev_wdata <= ctl_mem_write;
        if (ctl_mem_write_strb) begin
            wr_log.push_back(ctl_mem_write);
            if (prev_wstrb) gap_bad <= gap_bad + 1;
        end
        if (prev_wstrb && ctl_mem_write !== prev_wdata) hold_bad <= hold_bad + 1;
        if (ctl_run) run_count <= run_count + 1;
        if (ctl_mem_read_strb) rd_strb_count <= rd_strb_count + 1;
        if (busy) busy_count <= busy_count + 1;
        if (wr_ready) wr_ready_count <= wr_ready_count + 1;
        if (rsp_valid) rsp_valid_count <= rsp_valid_count + 1;
    end

    // Driver state
    logic [31:0] payload [0:63];
    logic [31:0] rsp_q [$];
    logic        last_q [$];
    int          stall_bad;
    bit          drv_timeout = 1'b0;

    task automatic prepare();
        for (int i = 0; i < 64; i++) begin
            payload[i] = $urandom;
            model_mask[i] = $urandom;
        end
    endtask

    task automatic send_cmd(input logic [31:0] len);
        int budget = 50;
        @(negedge axi_clk);
        cmd_valid = 1'b1;
        cmd_len_bits = len;
        while (!cmd_ready && budget > 0) begin
            @(negedge axi_clk);
            budget--;
        end
        if (budget == 0) drv_timeout = 1'b1;
        @(negedge axi_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_payload(input int n, input bit gappy);
        int  i = 0;
        int  budget = 600;
        logic accepted;
        while (i < n && budget > 0) begin
            wr_valid = gappy ? ($urandom_range(0, 3) != 0) : 1'b1;
            wr_data = wr_valid ? payload[i] : $urandom;
            accepted = wr_valid && wr_ready;
            @(negedge axi_clk);
            if (accepted) i++;
            budget--;
        end
        wr_valid = 1'b0;
        if (i < n) drv_timeout = 1'b1;
    endtask

    task automatic collect_rsp(input int stall_idx, input int stall_cycles, input int budget);
        int          idx = 0;
        int          left = stall_cycles;
        int          held_strb = 0;
        logic [31:0] held = '0;
        bit          done = 1'b0;
        rsp_q.delete();
        last_q.delete();
        stall_bad = 0;
        while (!done && budget > 0) begin
            @(negedge axi_clk);
            budget--;
            if (rsp_valid) begin
                if (idx == stall_idx && left > 0) begin
                    if (left == stall_cycles) begin
                        held = rsp_data;
                        held_strb = rd_strb_count;
                    end else if (rsp_data !== held || rd_strb_count != held_strb) begin
                        stall_bad++;
                    end
                    rsp_ready = 1'b0;
                    left--;
                end else begin
                    rsp_ready = 1'b1;
                    rsp_q.push_back(rsp_data);
                    last_q.push_back(rsp_last);
                    idx++;
                    if (rsp_last || idx >= MEM_DEPTH) done = 1'b1;
                end
            end else begin
                rsp_ready = 1'b0;
            end
        end
        @(negedge axi_clk);
        rsp_ready = 1'b0;
        repeat (3) @(negedge axi_clk);
    endtask

    task automatic test_reset();
        total_checks++;
        if ({wr_ready, rsp_valid, rsp_data, rsp_last, ctl_mem_write, ctl_mem_write_strb,
             ctl_mem_write_ptr_reset, ctl_mem_read_strb, ctl_mem_read_ptr_reset,
             ctl_transaction_len, ctl_run, busy, err_len, err_timeout} !== '0) begin
            bad_checks++;
            $display("[TB] FAIL reset_outputs: some output nonzero (rsp_data=%0h mem_write=%0h len=%0h busy=%0b)",
                     rsp_data, ctl_mem_write, ctl_transaction_len, busy);
        end
        total_checks++;
        if (cmd_ready !== 1'b1) begin
            bad_checks++;
            $display("[TB] FAIL reset_cmd_ready: got %0b expected 1", cmd_ready);
        end
    endtask

    task automatic test_basic();
        int base_wr = wr_log.size();
        int base_run = run_count;
        int base_rd = rd_strb_count;
        int base_gap = gap_bad;
        int base_hold = hold_bad;
        prepare();
        payload[0] = 32'hDEADBEEF;
        payload[1] = 32'h12345678;
        send_cmd(32'd64);
        send_payload(2, 1'b0);
        collect_rsp(-1, 0, 2000);
        total_checks++;
        if (drv_timeout) begin bad_checks++; $display("[TB] FAIL basic_handshake: driver wait expired"); end
        total_checks++;
        if (wr_log.size() - base_wr != 2) begin
            bad_checks++; $display("[TB] FAIL basic_strobes: got %0d expected 2", wr_log.size() - base_wr);
        end else begin
            total_checks++;
            if (wr_log[base_wr] !== 32'hDEADBEEF || wr_log[base_wr + 1] !== 32'h12345678) begin
                bad_checks++;
                $display("[TB] FAIL basic_wdata: got %0h,%0h expected deadbeef,12345678",
                         wr_log[base_wr], wr_log[base_wr + 1]);
            end
        end
        total_checks++;
        if (gap_bad != base_gap || hold_bad != base_hold) begin
            bad_checks++;
            $display("[TB] FAIL basic_pacing: gap errors %0d hold errors %0d expected 0,0",
                     gap_bad - base_gap, hold_bad - base_hold);
        end
        total_checks++;
        if (run_count - base_run != 1) begin
            bad_checks++; $display("[TB] FAIL basic_run: got %0d pulses expected 1", run_count - base_run);
        end
        total_checks++;
        if (rsp_q.size() != 2) begin
            bad_checks++; $display("[TB] FAIL basic_rsp_count: got %0d expected 2", rsp_q.size());
        end else begin
            total_checks++;
            if (rsp_q[0] !== (32'hDEADBEEF ^ model_mask[0]) || rsp_q[1] !== (32'h12345678 ^ model_mask[1])) begin
                bad_checks++;
                $display("[TB] FAIL basic_rsp_data: got %0h,%0h expected %0h,%0h", rsp_q[0], rsp_q[1],
                         32'hDEADBEEF ^ model_mask[0], 32'h12345678 ^ model_mask[1]);
            end
            total_checks++;
            if (last_q[0] !== 1'b0 || last_q[1] !== 1'b1) begin
                bad_checks++; $display("[TB] FAIL basic_rsp_last: got %0b%0b expected 01", last_q[0], last_q[1]);
            end
        end
        total_checks++;
        if (rd_strb_count - base_rd != 2) begin
            bad_checks++; $display("[TB] FAIL basic_read_strobes: got %0d expected 2", rd_strb_count - base_rd);
        end
        total_checks++;
        if (ctl_transaction_len !== 32'd64 || busy !== 1'b0) begin
            bad_checks++;
            $display("[TB] FAIL basic_len_idle: len %0d busy %0b expected 64,0", ctl_transaction_len, busy);
        end
    endtask

    task automatic test_lengths();
        logic [31:0] lens [$];
        lens = '{32'd33, 32'd32, 32'd2048};
        repeat (3) lens.push_back($urandom_range(1, 700));
        foreach (lens[k]) begin
            int  n = int'((longint'(lens[k]) + 31) / 32);
            int  base_wr = wr_log.size();
            int  base_run = run_count;
            int  base_gap = gap_bad;
            int  base_hold = hold_bad;
            bit  gappy = (k >= 3);
            drv_timeout = 1'b0;
            prepare();
            send_cmd(lens[k]);
            send_payload(n, gappy);
            collect_rsp(-1, 0, 3000);
            total_checks++;
            if (drv_timeout || ctl_transaction_len !== lens[k]) begin
                bad_checks++;
                $display("[TB] FAIL len%0d_accept: timeout %0b len reg %0d", lens[k], drv_timeout, ctl_transaction_len);
            end
            total_checks++;
            if (wr_log.size() - base_wr != n || run_count - base_run != 1) begin
                bad_checks++;
                $display("[TB] FAIL len%0d_loads: strobes %0d runs %0d expected %0d,1", lens[k],
                         wr_log.size() - base_wr, run_count - base_run, n);
            end
            total_checks++;
            if (gap_bad != base_gap || hold_bad != base_hold) begin
                bad_checks++;
                $display("[TB] FAIL len%0d_pacing: gap %0d hold %0d expected 0,0", lens[k],
                         gap_bad - base_gap, hold_bad - base_hold);
            end
            total_checks++;
            if (rsp_q.size() != n) begin
                bad_checks++;
                $display("[TB] FAIL len%0d_rsp_count: got %0d expected %0d", lens[k], rsp_q.size(), n);
            end
            for (int i = 0; i < rsp_q.size() && i < n; i++) begin
                total_checks++;
                if (rsp_q[i] !== (payload[i] ^ model_mask[i]) || last_q[i] !== (i == n - 1)) begin
                    bad_checks++;
                    $display("[TB] FAIL len%0d_rsp%0d: got %0h last %0b expected %0h last %0b", lens[k], i,
                             rsp_q[i], last_q[i], payload[i] ^ model_mask[i], (i == n - 1));
                end
            end
        end
    endtask

    task automatic test_zero_len();
        int base_busy = busy_count;
        int base_wr = wr_log.size();
        int base_run = run_count;
        int base_rsp = rsp_valid_count;
        drv_timeout = 1'b0;
        send_cmd(32'd0);
        repeat (20) @(negedge axi_clk);
        total_checks++;
        if (drv_timeout || ctl_transaction_len !== 32'd0) begin
            bad_checks++; $display("[TB] FAIL zero_accept: timeout %0b len %0d", drv_timeout, ctl_transaction_len);
        end
        total_checks++;
        if (busy_count != base_busy || wr_log.size() != base_wr || run_count != base_run || rsp_valid_count != base_rsp) begin
            bad_checks++;
            $display("[TB] FAIL zero_activity: busy %0d strobes %0d runs %0d rsp %0d expected all 0",
                     busy_count - base_busy, wr_log.size() - base_wr, run_count - base_run, rsp_valid_count - base_rsp);
        end
    endtask

    task automatic test_len_err();
        int base_busy = busy_count;
        int base_wrr = wr_ready_count;
        int base_wr = wr_log.size();
        drv_timeout = 1'b0;
        send_cmd(32'd2049);
        wr_valid = 1'b1;
        wr_data = $urandom;
        repeat (20) @(negedge axi_clk);
        wr_valid = 1'b0;
        total_checks++;
        if (err_len !== 1'b1) begin
            bad_checks++; $display("[TB] FAIL lenerr_flag: got %0b expected 1", err_len);
        end
        total_checks++;
        if (wr_ready_count != base_wrr || busy_count != base_busy || wr_log.size() != base_wr || cmd_ready !== 1'b1) begin
            bad_checks++;
            $display("[TB] FAIL lenerr_idle: wr_ready %0d busy %0d strobes %0d cmd_ready %0b",
                     wr_ready_count - base_wrr, busy_count - base_busy, wr_log.size() - base_wr, cmd_ready);
        end
        prepare();
        send_cmd(32'd32);
        total_checks++;
        if (err_len !== 1'b0) begin
            bad_checks++; $display("[TB] FAIL lenerr_clear: got %0b expected 0", err_len);
        end
        send_payload(1, 1'b0);
        collect_rsp(-1, 0, 2000);
        total_checks++;
        if (drv_timeout || rsp_q.size() != 1 || (rsp_q.size() == 1 && rsp_q[0] !== (payload[0] ^ model_mask[0]))) begin
            bad_checks++;
            $display("[TB] FAIL lenerr_recover: words %0d first %0h expected 1 word %0h", rsp_q.size(),
                     (rsp_q.size() > 0) ? rsp_q[0] : 32'h0, payload[0] ^ model_mask[0]);
        end
    endtask

    task automatic test_timeout();
        int budget = 200;
        int k = 0;
        int base_rsp = rsp_valid_count;
        drv_timeout = 1'b0;
        model_hang = 1'b1;
        prepare();
        send_cmd(32'd64);
        send_payload(2, 1'b0);
        while (!ctl_run && budget > 0) begin @(negedge axi_clk); budget--; end
        budget = 400;
        while (!err_timeout && budget > 0) begin @(negedge axi_clk); k++; budget--; end
        // TO_CYCLES cycles spent waiting; the flag is visible on the cycle after
        total_checks++;
        if (k != TO_CYCLES + 1) begin
            bad_checks++; $display("[TB] FAIL timeout_latency: got %0d cycles expected %0d", k, TO_CYCLES + 1);
        end
        repeat (10) @(negedge axi_clk);
        total_checks++;
        if (err_timeout !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid_count != base_rsp) begin
            bad_checks++;
            $display("[TB] FAIL timeout_idle: err %0b cmd_ready %0b busy %0b rsp %0d expected 1,1,0,0",
                     err_timeout, cmd_ready, busy, rsp_valid_count - base_rsp);
        end
        model_hang = 1'b0;
        repeat (busy_len + 5) @(negedge axi_clk);
        prepare();
        send_cmd(32'd32);
        total_checks++;
        if (err_timeout !== 1'b0) begin
            bad_checks++; $display("[TB] FAIL timeout_clear: got %0b expected 0", err_timeout);
        end
        send_payload(1, 1'b0);
        collect_rsp(-1, 0, 2000);
        total_checks++;
        if (drv_timeout || rsp_q.size() != 1 || (rsp_q.size() == 1 && rsp_q[0] !== (payload[0] ^ model_mask[0]))) begin
            bad_checks++; $display("[TB] FAIL timeout_recover: words %0d expected 1", rsp_q.size());
        end
    endtask

    task automatic test_stall_and_reset();
        int base_rd = rd_strb_count;
        drv_timeout = 1'b0;
        prepare();
        send_cmd(32'd96);
        send_payload(3, 1'b1);
        collect_rsp(1, 10, 3000);
        total_checks++;
        if (stall_bad != 0 || rd_strb_count - base_rd != 3) begin
            bad_checks++;
            $display("[TB] FAIL stall_hold: unstable samples %0d read strobes %0d expected 0,3",
                     stall_bad, rd_strb_count - base_rd);
        end
        total_checks++;
        if (rsp_q.size() != 3) begin
            bad_checks++; $display("[TB] FAIL stall_rsp_count: got %0d expected 3", rsp_q.size());
        end
        for (int i = 0; i < rsp_q.size() && i < 3; i++) begin
            total_checks++;
            if (rsp_q[i] !== (payload[i] ^ model_mask[i]) || last_q[i] !== (i == 2)) begin
                bad_checks++;
                $display("[TB] FAIL stall_rsp%0d: got %0h last %0b expected %0h", i, rsp_q[i], last_q[i],
                         payload[i] ^ model_mask[i]);
            end
        end
        prepare();
        send_cmd(32'd96);
        send_payload(1, 1'b0);
        @(negedge axi_clk);
        #2 axi_resetn = 1'b0;
        #1 test_reset();
        @(negedge axi_clk);
        axi_resetn = 1'b1;
        prepare();
        send_cmd(32'd40);
        send_payload(2, 1'b1);
        collect_rsp(-1, 0, 2000);
        total_checks++;
        if (drv_timeout || rsp_q.size() != 2) begin
            bad_checks++; $display("[TB] FAIL reset_recover_count: got %0d words expected 2", rsp_q.size());
        end else begin
            total_checks++;
            if (rsp_q[0] !== (payload[0] ^ model_mask[0]) || rsp_q[1] !== (payload[1] ^ model_mask[1]) ||
                last_q[1] !== 1'b1) begin
                bad_checks++;
                $display("[TB] FAIL reset_recover_data: got %0h,%0h expected %0h,%0h", rsp_q[0], rsp_q[1],
                         payload[0] ^ model_mask[0], payload[1] ^ model_mask[1]);
            end
        end
    endtask

    // Hard stop if a scenario wedges despite its own wait budgets
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 test_reset();
        repeat (3) @(negedge axi_clk);
        axi_resetn = 1'b1;
        test_reset();
        test_basic();
        test_lengths();
        test_zero_len();
        test_len_err();
        test_timeout();
        test_stall_and_reset();
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
